// File: rtl/mmu_cache_pkg.sv
// Shared types for the MMU-side cache arbiter: requester IDs, FSM states and helpers.
package mmu_cache_pkg;

  typedef enum logic [1:0] {
    IMMU = 2'd0,
    DMMU = 2'd1,
    CPU  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int         NUM_REQ    = 3;
  localparam logic [3:0] STARVE_MAX = 4'd15;

  // Requester that follows o in round-robin order
  function automatic owner_e owner_next(input owner_e o);
    return (o == CPU) ? IMMU : owner_e'(o + 2'd1);
  endfunction

  function automatic owner_e gnt2owner(input logic [NUM_REQ-1:0] g);
    if (g[CPU])       return CPU;
    else if (g[DMMU]) return DMMU;
    else              return IMMU;
  endfunction

endpackage

// File: rtl/mmu_arb_pick.sv
// Combinational 3-way picker: fixed priority with a CPU starvation override, or
// round-robin starting from rr_ptr. Returns a one-hot grant.
module mmu_arb_pick
  import mmu_cache_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic               rr_mode,
  input  owner_e             rr_ptr,
  input  logic               starve,
  output logic [NUM_REQ-1:0] gnt
);

  owner_e idx;
  logic   found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = rr_mode ? rr_ptr : IMMU;
    if (!rr_mode && starve && req_vld[CPU]) begin
      gnt[CPU] = 1'b1;
      found    = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_vld[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = owner_next(idx);
    end
  end

endmodule

// File: rtl/mmu_cache_arbiter.sv
// Shares the cache CPU port between IMMU walker, DMMU walker and the LSU, one
// transaction at a time. Define MMU_CACHE_ARB_RR_EN for round-robin arbitration.
module mmu_cache_arbiter
  import mmu_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    immu_req_valid,
  output logic                    immu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   immu_addr,
  output logic                    immu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   immu_rdata,
  input  logic                    dmmu_req_valid,
  output logic                    dmmu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   dmmu_addr,
  output logic                    dmmu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   dmmu_rdata,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic                    cpu_wen,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wmask,
  output logic                    cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic [ADDR_WIDTH-1:0]   cache_addr,
  output logic                    cache_ren,
  output logic                    cache_wen,
  output logic [DATA_WIDTH-1:0]   cache_wdata,
  output logic [DATA_WIDTH/8-1:0] cache_wmask,
  input  logic [DATA_WIDTH-1:0]   cache_rdata,
  input  logic                    cache_hit
);

  localparam int MASK_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_W-1:0]     wmask;
  } req_t;

  arb_state_e                          state_q, state_d;
  owner_e                              owner_q, win, rr_ptr;
  req_t                                req_q, req_win;
  logic [NUM_REQ-1:0]                  req_vld, gnt, rdy, rsp_vld;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  rdata_q;
  logic                                accept, starve, rr_mode;

  assign req_vld = {cpu_req_valid, dmmu_req_valid, immu_req_valid};
  assign accept  = (state_q == IDLE) && (|req_vld);
  assign win     = gnt2owner(gnt);

`ifdef MMU_CACHE_ARB_RR_EN
  owner_e rr_ptr_q;

  assign rr_mode = 1'b1;
  assign starve  = 1'b0;
  assign rr_ptr  = rr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr_q <= IMMU;
    else if (accept) rr_ptr_q <= owner_next(win);
  end
`else
  logic [3:0] starve_cnt_q;

  assign rr_mode = 1'b0;
  assign rr_ptr  = IMMU;
  assign starve  = (starve_cnt_q == STARVE_MAX);

  // Counts arbitrations the waiting CPU lost; saturates, cleared on CPU grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (accept) begin
      if (gnt[CPU])
        starve_cnt_q <= '0;
      else if (cpu_req_valid && starve_cnt_q != STARVE_MAX)
        starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end
`endif

  mmu_arb_pick u_pick (
    .req_vld (req_vld),
    .rr_mode (rr_mode),
    .rr_ptr  (rr_ptr),
    .starve  (starve),
    .gnt     (gnt)
  );

  // Walkers only read; their write fields stay zero
  always_comb begin
    req_win = '0;
    case (win)
      IMMU: req_win.addr = immu_addr;
      DMMU: req_win.addr = dmmu_addr;
      default: begin
        req_win.addr  = cpu_addr;
        req_win.wen   = cpu_wen;
        req_win.wdata = cpu_wdata;
        req_win.wmask = cpu_wmask;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rdy       = '0;
    rsp_vld   = '0;
    cache_ren = 1'b0;
    cache_wen = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = gnt;
        if (|req_vld) state_d = BUSY;
      end
      BUSY: begin
        cache_ren = ~req_q.wen;
        cache_wen = req_q.wen;
        if (cache_hit) state_d = RESP;
      end
      RESP: begin
        rsp_vld[owner_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= IMMU;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= win;
        req_q   <= req_win;
      end
      if (state_q == BUSY && cache_hit)
        rdata_q[owner_q] <= req_q.wen ? '0 : cache_rdata;
    end
  end

  assign immu_req_ready = rdy[IMMU];
  assign dmmu_req_ready = rdy[DMMU];
  assign cpu_req_ready  = rdy[CPU];
  assign immu_rsp_valid = rsp_vld[IMMU];
  assign dmmu_rsp_valid = rsp_vld[DMMU];
  assign cpu_rsp_valid  = rsp_vld[CPU];
  assign immu_rdata     = rdata_q[IMMU];
  assign dmmu_rdata     = rdata_q[DMMU];
  assign cpu_rdata      = rdata_q[CPU];
  assign cache_addr     = req_q.addr;
  assign cache_wdata    = req_q.wdata;
  assign cache_wmask    = req_q.wmask;

endmodule

// File: tb/tb_mmu_cache_arbiter.sv
// Scoreboard bench for mmu_cache_arbiter with a behavioural cache that hits after a set delay.
module tb_mmu_cache_arbiter;
  import mmu_cache_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          immu_req_valid, immu_req_ready, immu_rsp_valid;
  logic [AW-1:0] immu_addr;
  logic [DW-1:0] immu_rdata;
  logic          dmmu_req_valid, dmmu_req_ready, dmmu_rsp_valid;
  logic [AW-1:0] dmmu_addr;
  logic [DW-1:0] dmmu_rdata;
  logic          cpu_req_valid, cpu_req_ready, cpu_rsp_valid, cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic [MW-1:0] cpu_wmask;
  logic [AW-1:0] cache_addr;
  logic          cache_ren, cache_wen;
  logic [DW-1:0] cache_wdata;
  logic [MW-1:0] cache_wmask;
  logic [DW-1:0] cache_rdata = '0;
  logic          cache_hit = 1'b0;

  mmu_cache_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst),
    .immu_req_valid(immu_req_valid), .immu_req_ready(immu_req_ready), .immu_addr(immu_addr),
    .immu_rsp_valid(immu_rsp_valid), .immu_rdata(immu_rdata),
    .dmmu_req_valid(dmmu_req_valid), .dmmu_req_ready(dmmu_req_ready), .dmmu_addr(dmmu_addr),
    .dmmu_rsp_valid(dmmu_rsp_valid), .dmmu_rdata(dmmu_rdata),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_wen(cpu_wen), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_ren(cache_ren), .cache_wen(cache_wen),
    .cache_wdata(cache_wdata), .cache_wmask(cache_wmask),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, n_rsp = 0;
  int   rdy_cyc[3] = '{0, 0, 0};
  int   n_gnt[3]   = '{0, 0, 0};
  bit   sticky[3]  = '{0, 0, 0};
  bit   drop[3]    = '{0, 0, 0};
  int   hit_delay = 0, busy_cnt = 0;
  bit   force_hit = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm, input string detail);
    n_chk++;
    $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
  endtask

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    return (a == 64'h1000) ? 64'h1234_5678 : (a ^ 64'hFFFF_0000_0000_0000);
  endfunction

  always @(posedge clk) cyc++;

  // Cache: hits hit_delay cycles after a request appears; junk data otherwise
  always @(posedge clk) begin
    #1;
    if (cache_ren || cache_wen) begin
      if (busy_cnt >= hit_delay) begin
        cache_hit   = 1'b1;
        busy_cnt    = 0;
        cache_rdata = cache_ren ? model_data(cache_addr) : 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        cache_hit   = 1'b0;
        busy_cnt++;
        cache_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end else begin
      cache_hit   = force_hit;
      busy_cnt    = 0;
      cache_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Requesters drop valid the cycle after being accepted unless held sticky
  always @(posedge clk) begin
    #1;
    if (drop[0]) begin immu_req_valid = 1'b0; drop[0] = 1'b0; end
    if (drop[1]) begin dmmu_req_valid = 1'b0; drop[1] = 1'b0; end
    if (drop[2]) begin cpu_req_valid  = 1'b0; drop[2] = 1'b0; end
  end

  int            mon_nv, mon_o;
  logic [DW-1:0] mon_d;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (immu_req_ready) begin rdy_cyc[0] = cyc; n_gnt[0]++; if (!sticky[0]) drop[0] = 1'b1; end
    if (dmmu_req_ready) begin rdy_cyc[1] = cyc; n_gnt[1]++; if (!sticky[1]) drop[1] = 1'b1; end
    if (cpu_req_ready)  begin rdy_cyc[2] = cyc; n_gnt[2]++; if (!sticky[2]) drop[2] = 1'b1; end
    if (int'(immu_req_ready) + int'(dmmu_req_ready) + int'(cpu_req_ready) > 1)
      fail_now("one_ready", $sformatf("readys %b%b%b, at most one allowed",
                                      immu_req_ready, dmmu_req_ready, cpu_req_ready));
    mon_nv = int'(immu_rsp_valid) + int'(dmmu_rsp_valid) + int'(cpu_rsp_valid);
    if (mon_nv > 1) begin
      fail_now("one_rsp", $sformatf("rsp_valids %b%b%b, at most one allowed",
                                    immu_rsp_valid, dmmu_rsp_valid, cpu_rsp_valid));
    end else if (mon_nv == 1) begin
      n_rsp++;
      mon_o = immu_rsp_valid ? 0 : (dmmu_rsp_valid ? 1 : 2);
      mon_d = immu_rsp_valid ? immu_rdata : (dmmu_rsp_valid ? dmmu_rdata : cpu_rdata);
      if (sbq.size() == 0) begin
        fail_now("unexpected_rsp", $sformatf("got rsp from owner %0d data %0h, expected none",
                                             mon_o, mon_d));
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_owner", mon_o, mon_e.owner);
        check("rsp_data", mon_d, mon_e.data);
        check("rsp_latency", cyc - rdy_cyc[mon_o], mon_e.lat);
      end
    end
  end

  task automatic expect_rsp(input int o, input logic [DW-1:0] d, input int lat);
    exp_t e;
    e.owner = o; e.data = d; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic issue(input int o, input logic [AW-1:0] a, input bit we,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    case (o)
      0: begin immu_addr = a; immu_req_valid = 1'b1; end
      1: begin dmmu_addr = a; dmmu_req_valid = 1'b1; end
      default: begin
        cpu_addr = a; cpu_wen = we; cpu_wdata = wd; cpu_wmask = wm; cpu_req_valid = 1'b1;
      end
    endcase
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (k < budget && (sbq.size() != 0 || immu_req_valid || dmmu_req_valid || cpu_req_valid)) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0 || immu_req_valid || dmmu_req_valid || cpu_req_valid)
      fail_now(nm, $sformatf("timeout with %0d responses outstanding, expected 0", sbq.size()));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctrl"}, {immu_req_ready, dmmu_req_ready, cpu_req_ready,
                          immu_rsp_valid, dmmu_rsp_valid, cpu_rsp_valid, cache_ren, cache_wen}, '0);
    check({nm, "_rdata"}, {immu_rdata, dmmu_rdata, cpu_rdata}, '0);
    check({nm, "_cache"}, {cache_addr, cache_wdata, cache_wmask}, '0);
    check({nm, "_state"}, u_dut.state_q, IDLE);
  endtask

  int k, g_cpu, g_immu, rsp0;

  initial begin
    immu_req_valid = 0; dmmu_req_valid = 0; cpu_req_valid = 0;
    immu_addr = '0; dmmu_addr = '0; cpu_addr = '0;
    cpu_wen = 0; cpu_wdata = '0; cpu_wmask = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2 rst = 1'b0;

    // All three at once: fixed order IMMU, DMMU, CPU; immediate hit
    @(posedge clk); #2;
    hit_delay = 0;
    expect_rsp(0, 64'hFFFF_0000_0000_0100, 2);
    expect_rsp(1, 64'hFFFF_0000_0000_0200, 2);
    expect_rsp(2, 64'hFFFF_0000_0000_0300, 2);
    issue(0, 64'h100, 0, '0, '0);
    issue(1, 64'h200, 0, '0, '0);
    issue(2, 64'h300, 0, '0, '0);
    wait_done("multi", 100);

    // Spurious hit while idle
    @(posedge clk); #2 force_hit = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("spur_rsp", {immu_rsp_valid, dmmu_rsp_valid, cpu_rsp_valid}, '0);
      check("spur_state", u_dut.state_q, IDLE);
    end
    @(posedge clk); #2 force_hit = 1'b0;
    repeat (2) @(negedge clk);

    // DMMU read with a short refill
    @(posedge clk); #2;
    hit_delay = 3;
    expect_rsp(1, 64'h1234_5678, 5);
    issue(1, 64'h1000, 0, '0, '0);
    wait_done("dmmu_read", 100);

    // CPU store, hit held off for 20 cycles
    @(posedge clk); #2;
    hit_delay = 20;
    expect_rsp(2, '0, 22);
    issue(2, 64'h80, 1, 64'hDEAD, 8'h03);
    k = 0;
    while (!cache_wen && k < 10) begin @(negedge clk); k++; end
    if (!cache_wen) begin
      fail_now("store_start", "cache_wen never rose, expected 1 within 10 cycles");
    end else begin
      for (int i = 0; i < 20; i++) begin
        check("store_hold", {cache_wen, cache_ren, cache_addr, cache_wdata, cache_wmask},
              {1'b1, 1'b0, 64'h80, 64'hDEAD, 8'h03});
        @(negedge clk);
      end
    end
    wait_done("store", 100);

    // Continuous IMMU vs CPU from a fresh reset
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    hit_delay = 0;
`ifdef MMU_CACHE_ARB_RR_EN
    expect_rsp(0, 64'hFFFF_0000_0000_2000, 2);
`else
    for (int i = 0; i < 15; i++) expect_rsp(0, 64'hFFFF_0000_0000_2000, 2);
`endif
    expect_rsp(2, 64'hFFFF_0000_0000_3000, 2);
    g_cpu = n_gnt[2]; g_immu = n_gnt[0];
    sticky[0] = 1'b1; sticky[2] = 1'b1;
    issue(0, 64'h2000, 0, '0, '0);
    issue(2, 64'h3000, 0, '0, '0);
    k = 0;
    while (n_gnt[2] == g_cpu && k < 300) begin @(negedge clk); k++; end
    if (n_gnt[2] == g_cpu) fail_now("starve_cpu_grant", "CPU never granted, expected a grant");
    @(posedge clk); #2;
    immu_req_valid = 1'b0; cpu_req_valid = 1'b0;
    sticky[0] = 1'b0; sticky[2] = 1'b0;
`ifdef MMU_CACHE_ARB_RR_EN
    check("starve_immu_grants", n_gnt[0] - g_immu, 1);
`else
    check("starve_immu_grants", n_gnt[0] - g_immu, 15);
`endif
    wait_done("starve", 100);

    // Reset in the middle of a long IMMU read: no response ever
    @(posedge clk); #2;
    hit_delay = 10;
    issue(0, 64'h40, 0, '0, '0);
    k = 0;
    while (!cache_ren && k < 10) begin @(negedge clk); k++; end
    if (!cache_ren) fail_now("abort_start", "cache_ren never rose, expected 1 within 10 cycles");
    repeat (2) @(negedge clk);
    rsp0 = n_rsp;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    @(posedge clk); #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_rsp", n_rsp - rsp0, 0);
    hit_delay = 0;

    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
